// File: rtl/sci_fifo.sv
// sci_fifo: MiniS08 buffered serial interface with tx/rx FIFOs,
// 16x receive oversampling, optional parity and sticky error flags.
module sci_fifo #(
    parameter int unsigned BAUD_DIV   = 27,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       IOsel,
    input  logic [2:0] addr,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] datain,
    output logic [7:0] dataout,
    input  logic       rxd,
    output logic       txd
);
    localparam int unsigned TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(BAUD_DIV - 1);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {RIDLE, RSTART, RDATA, RPAR, RSTOP, RBRK} rx_st_e;
    typedef enum logic [2:0] {TIDLE, TSTART, TDATA, TPAR, TSTOP} tx_st_e;

    logic [TW-1:0] tick_cnt_q;
    logic          tick;
    logic [3:0]    acc, acc_q, fire;
    logic          pe_q, podd_q;
    logic          rx_s1_q, rx_s2_q;
    logic          or_q, pf_q, fe_q;
    rx_st_e        rx_st_q;
    logic [3:0]    rsub_q;
    logic [2:0]    rbit_q;
    logic [7:0]    rsh_q;
    logic          rpe_q, rpodd_q, rx_push_q;
    tx_st_e        tx_st_q;
    logic [3:0]    tsub_q;
    logic [2:0]    tbit_q;
    logic [7:0]    tsh_q;
    logic          tpe_q, tpodd_q, txd_q;
    logic          tx_load;
    logic [7:0]    status;

    // index 0 is the tx FIFO, index 1 the rx FIFO
    logic [1:0]      f_push, f_pop, f_empty, f_full;
    logic [1:0][7:0] f_din, f_head;

    assign f_din  = {rsh_q, datain};
    assign f_push = {rx_push_q, fire[2]};
    assign f_pop  = {fire[1], tx_load};

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [7:0]    mem_q [FIFO_DEPTH];
        logic [AW-1:0] wr_q, rd_q;
        logic [AW:0]   cnt_q;
        logic          do_push, do_pop;

        assign f_empty[g] = (cnt_q == '0);
        assign f_full[g]  = (cnt_q == FULL_CNT);
        assign f_head[g]  = mem_q[rd_q];
        assign do_pop     = f_pop[g] & ~f_empty[g];
        assign do_push    = f_push[g] & (~f_full[g] | do_pop);

        always_ff @(posedge clk) begin
            if (do_push) mem_q[wr_q] <= f_din[g];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (do_push) wr_q <= wr_q + AW'(1);
                if (do_pop) rd_q <= rd_q + AW'(1);
                cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
            end
        end
    end

    assign tick = (tick_cnt_q == TICK_MAX);

    // bit0 status rd, bit1 data rd, bit2 data wr, bit3 control wr
    assign acc = {IOsel & write & (addr == 3'd7),
                  IOsel & write & (addr == 3'd6),
                  IOsel & read  & (addr == 3'd5),
                  IOsel & read  & (addr == 3'd4)};
    assign fire = acc & ~acc_q;

    assign status = {~f_full[0], f_empty[0] & (tx_st_q == TIDLE),
                     or_q, pf_q, fe_q, 2'b00, ~f_empty[1]};

    always_comb begin
        dataout = '0;
        if (IOsel && read) begin
            case (addr)
                3'd4:    dataout = status;
                3'd5:    dataout = f_empty[1] ? 8'h00 : f_head[1];
                3'd7:    dataout = {6'b0, podd_q, pe_q};
                default: dataout = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            acc_q      <= '0;
            pe_q       <= 1'b0;
            podd_q     <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
            acc_q      <= acc;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            if (fire[3]) begin
                pe_q   <= datain[0];
                podd_q <= datain[1];
            end
        end
    end

    // Receiver: framing settings are captured at the start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_st_q   <= RIDLE;
            rsub_q    <= '0;
            rbit_q    <= '0;
            rsh_q     <= '0;
            rpe_q     <= 1'b0;
            rpodd_q   <= 1'b0;
            rx_push_q <= 1'b0;
            or_q      <= 1'b0;
            pf_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            rx_push_q <= 1'b0;
            if (fire[0]) begin
                or_q <= 1'b0;
                pf_q <= 1'b0;
                fe_q <= 1'b0;
            end
            if (rx_push_q && f_full[1] && !fire[1]) or_q <= 1'b1;
            if (tick) begin
                rsub_q <= rsub_q + 4'd1;
                case (rx_st_q)
                    RIDLE: begin
                        rsub_q <= '0;
                        if (!rx_s2_q) begin
                            rx_st_q <= RSTART;
                            rpe_q   <= pe_q;
                            rpodd_q <= podd_q;
                        end
                    end
                    RSTART: if (rsub_q == 4'd7) begin
                        rsub_q  <= '0;
                        rbit_q  <= '0;
                        rx_st_q <= rx_s2_q ? RIDLE : RDATA;
                    end
                    RDATA: if (rsub_q == 4'd15) begin
                        rsh_q  <= {rx_s2_q, rsh_q[7:1]};
                        rbit_q <= rbit_q + 3'd1;
                        if (rbit_q == 3'd7) rx_st_q <= rpe_q ? RPAR : RSTOP;
                    end
                    RPAR: if (rsub_q == 4'd15) begin
                        if ((^rsh_q ^ rx_s2_q) != rpodd_q) pf_q <= 1'b1;
                        rx_st_q <= RSTOP;
                    end
                    RSTOP: if (rsub_q == 4'd15) begin
                        rx_push_q <= 1'b1;
                        if (!rx_s2_q) begin
                            fe_q    <= 1'b1;
                            rx_st_q <= RBRK;
                        end else begin
                            rx_st_q <= RIDLE;
                        end
                    end
                    RBRK:    if (rx_s2_q) rx_st_q <= RIDLE;
                    default: rx_st_q <= RIDLE;
                endcase
            end
        end
    end

    assign tx_load = tick & ~f_empty[0] &
                     ((tx_st_q == TIDLE) |
                      ((tx_st_q == TSTOP) & (tsub_q == 4'd15)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_st_q <= TIDLE;
            tsub_q  <= '0;
            tbit_q  <= '0;
            tsh_q   <= '0;
            tpe_q   <= 1'b0;
            tpodd_q <= 1'b0;
            txd_q   <= 1'b1;
        end else if (tick) begin
            tsub_q <= tsub_q + 4'd1;
            if (tx_load) begin
                tx_st_q <= TSTART;
                tsub_q  <= '0;
                tsh_q   <= f_head[0];
                tpe_q   <= pe_q;
                tpodd_q <= podd_q;
                txd_q   <= 1'b0;
            end else if (tsub_q == 4'd15) begin
                case (tx_st_q)
                    TSTART: begin
                        tx_st_q <= TDATA;
                        tbit_q  <= '0;
                        txd_q   <= tsh_q[0];
                    end
                    TDATA: if (tbit_q == 3'd7) begin
                        tx_st_q <= tpe_q ? TPAR : TSTOP;
                        txd_q   <= tpe_q ? (^tsh_q ^ tpodd_q) : 1'b1;
                    end else begin
                        tbit_q <= tbit_q + 3'd1;
                        txd_q  <= tsh_q[tbit_q + 3'd1];
                    end
                    TPAR: begin
                        tx_st_q <= TSTOP;
                        txd_q   <= 1'b1;
                    end
                    default: begin
                        tx_st_q <= TIDLE;
                        txd_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign txd = txd_q;

endmodule
